// File: rtl/crc32_append_if.sv
// Byte-stream interface for crc32_append: user payload in, payload + FCS out.
interface crc32_append_if;
    logic        user_tx_data_start;
    logic        user_tx_data_end;
    logic        user_tx_data_valid;
    logic [7:0]  user_tx_data;
    logic [15:0] packetlength;

    logic        crc_tx_data_start;
    logic        crc_tx_data_end;
    logic        crc_tx_data_valid;
    logic [7:0]  crc_tx_data;
    logic [15:0] crc_tx_pktlen;
    logic        drop_err;
    logic        len_err;

    modport master (
        output user_tx_data_start, user_tx_data_end, user_tx_data_valid, user_tx_data,
               packetlength,
        input  crc_tx_data_start, crc_tx_data_end, crc_tx_data_valid, crc_tx_data,
               crc_tx_pktlen, drop_err, len_err
    );

    modport slave (
        input  user_tx_data_start, user_tx_data_end, user_tx_data_valid, user_tx_data,
               packetlength,
        output crc_tx_data_start, crc_tx_data_end, crc_tx_data_valid, crc_tx_data,
               crc_tx_pktlen, drop_err, len_err
    );
endinterface

// File: rtl/crc32_append.sv
// Appends the reflected CRC-32 FCS (LSB byte first) to each user packet, one cycle latency.
// Optional length check against packetlength is enabled by defining CRC_LEN_CHECK_EN.
module crc32_append #(
    parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
    input logic           clk_User,
    input logic           reset,
    crc32_append_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StData, StFcs} state_e;

    state_e      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] fcs_q, fcs_d;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic [15:0] pktlen_q, pktlen_d;
    logic        out_start_q, out_start_d;
    logic        out_end_q, out_end_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        drop_q, drop_d;
    logic        len_err_d;
`ifdef CRC_LEN_CHECK_EN
    logic        len_err_q;
    logic [15:0] cnt_q, cnt_d, cnt_byte;
    logic        len_bad_q, len_bad_d;
`endif

    logic        in_start, in_end, accept;
    logic [31:0] crc_first, crc_next, crc_upd;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign in_start  = bus.user_tx_data_valid & bus.user_tx_data_start;
    assign in_end    = bus.user_tx_data_valid & bus.user_tx_data_end;
    assign crc_first = crc_byte(CRC_INIT, bus.user_tx_data);
    assign crc_next  = crc_byte(crc_q, bus.user_tx_data);
    // A start in DATA aborts the current packet and restarts from CRC_INIT.
    assign crc_upd   = in_start ? crc_first : crc_next;
    assign accept    = ((state_q == StIdle) & in_start) |
                       ((state_q == StData) & bus.user_tx_data_valid);

    always_ff @(posedge clk_User) begin
        if (reset) begin
            state_q     <= StIdle;
            crc_q       <= CRC_INIT;
            fcs_q       <= 32'h0;
            fcs_idx_q   <= 2'd0;
            pktlen_q    <= 16'h0;
            out_start_q <= 1'b0;
            out_end_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            drop_q      <= 1'b0;
`ifdef CRC_LEN_CHECK_EN
            len_err_q   <= 1'b0;
            cnt_q       <= 16'h0;
            len_bad_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            fcs_q       <= fcs_d;
            fcs_idx_q   <= fcs_idx_d;
            pktlen_q    <= pktlen_d;
            out_start_q <= out_start_d;
            out_end_q   <= out_end_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_q      <= drop_d;
`ifdef CRC_LEN_CHECK_EN
            len_err_q   <= len_err_d;
            cnt_q       <= cnt_d;
            len_bad_q   <= len_bad_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_start) state_d = in_end ? StFcs : StData;
            StData:  if (in_end) state_d = StFcs;
            StFcs:   if (fcs_idx_q == 2'd3) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        crc_d       = crc_q;
        fcs_d       = fcs_q;
        fcs_idx_d   = fcs_idx_q;
        pktlen_d    = pktlen_q;
        out_start_d = 1'b0;
        out_end_d   = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = 8'h00;
        len_err_d   = 1'b0;
        drop_d      = in_start & (state_q != StIdle);
`ifdef CRC_LEN_CHECK_EN
        cnt_d       = cnt_q;
        len_bad_d   = len_bad_q;
        cnt_byte    = in_start ? 16'd1 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.user_tx_data;
            out_start_d = in_start;
            crc_d       = crc_upd;
            if (in_start) pktlen_d = bus.packetlength;
`ifdef CRC_LEN_CHECK_EN
            cnt_d = cnt_byte;
`endif
            if (in_end) begin
                fcs_d     = crc_upd ^ CRC_XOROUT;
                fcs_idx_d = 2'd0;
`ifdef CRC_LEN_CHECK_EN
                len_bad_d = ({1'b0, cnt_byte} + 17'd4) != {1'b0, pktlen_d};
`endif
            end
        end else if (state_q == StFcs) begin
            out_valid_d = 1'b1;
            out_data_d  = fcs_q[7:0];
            fcs_d       = fcs_q >> 8;
            fcs_idx_d   = fcs_idx_q + 2'd1;
            out_end_d   = (fcs_idx_q == 2'd3);
`ifdef CRC_LEN_CHECK_EN
            len_err_d   = (fcs_idx_q == 2'd3) & len_bad_q;
`endif
        end
    end

    assign bus.crc_tx_data_start = out_start_q;
    assign bus.crc_tx_data_end   = out_end_q;
    assign bus.crc_tx_data_valid = out_valid_q;
    assign bus.crc_tx_data       = out_data_q;
    assign bus.crc_tx_pktlen     = pktlen_q;
    assign bus.drop_err          = drop_q;
`ifdef CRC_LEN_CHECK_EN
    assign bus.len_err           = len_err_q;
`else
    assign bus.len_err           = 1'b0;
`endif

endmodule

// File: tb/tb_crc32_append.sv
// Scoreboard bench for crc32_append: stimulus pushes expected beats, a negedge monitor pops them.
module tb_crc32_append;

    typedef struct packed {
        logic [7:0] data;
        logic       st;
        logic       en;
        logic       le;
        logic       contig;
    } beat_t;

    logic clk;
    logic reset;
    crc32_append_if bus ();

    crc32_append dut (
        .clk_User (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t      exp_q[$];
    logic [7:0] pkt[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         drops_seen = 0;
    int         exp_drops  = 0;
    int         cyc_n      = 0;
    int         last_cyc   = -10;
    beat_t      mb;
    logic [31:0] fcs_a;

    always @(negedge clk) begin
        cyc_n++;
        if (bus.drop_err) drops_seen++;
        if (bus.crc_tx_data_valid) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_beat: got data=%h start=%b end=%b, expected no output",
                         bus.crc_tx_data, bus.crc_tx_data_start, bus.crc_tx_data_end);
            end else begin
                mb = exp_q.pop_front();
                if (bus.crc_tx_data !== mb.data || bus.crc_tx_data_start !== mb.st ||
                    bus.crc_tx_data_end !== mb.en || bus.len_err !== mb.le ||
                    (mb.contig && cyc_n != last_cyc + 1)) begin
                    mismatched++;
                    $display("FAIL beat@%0d: got data=%h st=%b en=%b le=%b gap=%0d, expected data=%h st=%b en=%b le=%b contig=%b",
                             cyc_n, bus.crc_tx_data, bus.crc_tx_data_start, bus.crc_tx_data_end,
                             bus.len_err, cyc_n - last_cyc, mb.data, mb.st, mb.en, mb.le,
                             mb.contig);
                end
            end
            last_cyc = cyc_n;
        end else if (bus.crc_tx_data_start || bus.crc_tx_data_end || bus.len_err) begin
            compared++;
            mismatched++;
            $display("FAIL strobe_without_valid@%0d: got st=%b en=%b le=%b, expected 0", cyc_n,
                     bus.crc_tx_data_start, bus.crc_tx_data_end, bus.len_err);
        end
    end

    function automatic beat_t mk_beat(input logic [7:0] d, input logic s, input logic e,
                                      input logic l, input logic c);
        beat_t b;
        b.data = d; b.st = s; b.en = e; b.le = l; b.contig = c;
        return b;
    endfunction

    // Byte-wise reflected CRC-32 reference, final inversion included.
    function automatic logic [31:0] model_fcs();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (pkt[i]) begin
            c = c ^ {24'h0, pkt[i]};
            repeat (8) c = (c >> 1) ^ (32'hEDB8_8320 & {32{c[0]}});
        end
        return ~c;
    endfunction

    task automatic drive(input logic s, input logic e, input logic v, input logic [7:0] d,
                         input logic [15:0] len);
        bus.user_tx_data_start = s;
        bus.user_tx_data_end   = e;
        bus.user_tx_data_valid = v;
        bus.user_tx_data       = d;
        bus.packetlength       = len;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
    endtask

    task automatic send_pkt(input logic [15:0] len, input logic [31:0] fcs, input logic le,
                            input logic has_end, input int tail);
        int n;
        n = pkt.size();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk_beat(pkt[i], i == 0, 1'b0, 1'b0, i != 0));
            drive(i == 0, has_end && (i == n - 1), 1'b1, pkt[i], len);
        end
        if (has_end) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back(mk_beat(fcs[8*k +: 8], 1'b0, k == 3, (k == 3) && le, 1'b1));
            idle(tail);
        end
    endtask

    task automatic send_raw(input logic [15:0] len);
        for (int i = 0; i < pkt.size(); i++)
            drive(i == 0, i == pkt.size() - 1, 1'b1, pkt[i], len);
    endtask

    task automatic check_zero(input string name);
        compared++;
        if ({bus.crc_tx_data_start, bus.crc_tx_data_end, bus.crc_tx_data_valid,
             bus.crc_tx_data, bus.crc_tx_pktlen, bus.drop_err, bus.len_err} !== '0) begin
            mismatched++;
            $display("FAIL %s: got st=%b en=%b v=%b data=%h len=%h drop=%b le=%b, expected all 0",
                     name, bus.crc_tx_data_start, bus.crc_tx_data_end, bus.crc_tx_data_valid,
                     bus.crc_tx_data, bus.crc_tx_pktlen, bus.drop_err, bus.len_err);
        end
    endtask

    task automatic load_digits();
        pkt = {};
        for (int i = 0; i < 9; i++) pkt.push_back(8'(8'h31 + i));
    endtask

    initial begin
        reset = 1'b1;
        bus.user_tx_data_start = 1'b0;
        bus.user_tx_data_end   = 1'b0;
        bus.user_tx_data_valid = 1'b0;
        bus.user_tx_data       = 8'h00;
        bus.packetlength       = 16'h0;
        repeat (3) begin @(posedge clk); #1; check_zero("reset_init"); end
        reset = 1'b0;
        idle(2);

        // Reset held 3 cycles in the middle of a packet.
        pkt = {8'h10, 8'h11, 8'h12};
        send_pkt(16'd7, 32'h0, 1'b0, 1'b0, 0);
        reset = 1'b1;
        bus.user_tx_data_valid = 1'b0;
        bus.user_tx_data_start = 1'b0;
        repeat (3) begin @(posedge clk); #1; check_zero("reset_mid_packet"); end
        reset = 1'b0;
        idle(2);

        // "123456789" -> FCS 26 39 F4 CB; also checks pktlen latch.
        load_digits();
        bus.packetlength = 16'd13;
        send_pkt(16'd13, 32'hCBF4_3926, 1'b0, 1'b1, 4);
        compared++;
        if (bus.crc_tx_pktlen !== 16'd13) begin
            mismatched++;
            $display("FAIL pktlen_latch: got %0d, expected 13", bus.crc_tx_pktlen);
        end

        // Single zero byte -> 00 8D EF 02 D2.
        pkt = {8'h00};
        send_pkt(16'd5, 32'hD202_EF8D, 1'b0, 1'b1, 4);

        // 150-byte ramp, repeated after a long idle gap.
        pkt = {};
        for (int i = 0; i < 150; i++) pkt.push_back(8'(i));
        fcs_a = model_fcs();
        send_pkt(16'd154, fcs_a, 1'b0, 1'b1, 4);
        idle(19900);
        send_pkt(16'd154, fcs_a, 1'b0, 1'b1, 4);

        // Start 2 cycles after end lands in the FCS window: dropped.
        load_digits();
        send_pkt(16'd13, 32'hCBF4_3926, 1'b0, 1'b1, 1);
        pkt = {8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        send_raw(16'd9);
        exp_drops++;
        idle(5);
        pkt = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
        send_pkt(16'd8, model_fcs(), 1'b0, 1'b1, 4);

        // Missing end: a new start aborts the packet with no FCS.
        pkt = {8'hC0, 8'hC1, 8'hC2};
        send_pkt(16'd7, 32'h0, 1'b0, 1'b0, 0);
        exp_drops++;
        pkt = {8'hD0, 8'hD1, 8'hD2, 8'hD3};
        send_pkt(16'd8, model_fcs(), 1'b0, 1'b1, 4);

        // Length mismatch: 9 bytes announced as 20.
        load_digits();
`ifdef CRC_LEN_CHECK_EN
        send_pkt(16'd20, 32'hCBF4_3926, 1'b1, 1'b1, 4);
`else
        send_pkt(16'd20, 32'hCBF4_3926, 1'b0, 1'b1, 4);
`endif

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        idle(3);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d beats still pending, expected 0", exp_q.size());
        end
        compared++;
        if (drops_seen != exp_drops) begin
            mismatched++;
            $display("FAIL drop_count: got %0d, expected %0d", drops_seen, exp_drops);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
